// File: rtl/rv_core_pkg.sv
// Shared core types and defaults for the fetch-side pc logic.
package rv_core_pkg;

  localparam int XLEN_DEFAULT        = 32;
  localparam int INSTR_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbitration: picks the winning request, masks its target and flags
// a misaligned jalr/branch destination. Purely combinational.
module pc_redirect_arb
  import rv_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            flow_en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            req,
  output logic [XLEN-1:0] target,
  output logic            fault
);

  logic [XLEN-1:0] jalr_eff;
  logic [XLEN-1:0] trap_eff;

  assign jalr_eff = jalr_target & ~XLEN'(1);
  assign trap_eff = trap_vector & ~XLEN'(3);

  // flow_en gates jalr/branch only; a trap is honoured in every state.
  always_comb begin
    req    = 1'b0;
    target = '0;
    fault  = 1'b0;
    if (trap_valid) begin
      req    = 1'b1;
      target = trap_eff;
    end else if (flow_en && jalr_valid) begin
      req    = 1'b1;
      target = jalr_eff;
      fault  = |jalr_eff[1:0];
    end else if (flow_en && branch_taken) begin
      req    = 1'b1;
      target = branch_target;
      fault  = |branch_target[1:0];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch pc sequencer: sequential advance, prioritised redirects and
// misaligned-target fault handling.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   BOOT  | one cycle after reset release, pc not yet valid; trap only
//   RUN   | pc valid, advances on fetch_ready & !stall, accepts redirects
//   FAULT | misaligned jalr/branch target seen, waits for a trap to exit
module pc_sequencer
  import rv_core_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            redirect,
  output logic            misaligned,
  output logic [XLEN-1:0] misaligned_addr
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            redirect_q, redirect_d;

  logic            arb_req;
  logic            arb_fault;
  logic [XLEN-1:0] arb_target;

  pc_redirect_arb #(.XLEN(XLEN)) u_arb (
    .flow_en       (state_q == RUN),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jalr_valid    (jalr_valid),
    .jalr_target   (jalr_target),
    .trap_valid    (trap_valid),
    .trap_vector   (trap_vector),
    .req           (arb_req),
    .target        (arb_target),
    .fault         (arb_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      maddr_q    <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      maddr_q    <= maddr_d;
      redirect_q <= redirect_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    maddr_d    = maddr_q;
    redirect_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (arb_req) begin
          pc_d       = arb_target;
          redirect_d = 1'b1;
        end
      end
      RUN: begin
        if (arb_req && arb_fault) begin
          state_d = FAULT;
          maddr_d = arb_target;
        end else if (arb_req) begin
          pc_d       = arb_target;
          redirect_d = 1'b1;
        end else if (fetch_ready && !stall) begin
          pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
      end
      FAULT: begin
        if (arb_req) begin
          state_d    = RUN;
          pc_d       = arb_target;
          redirect_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc              = pc_q;
  assign pc_valid        = (state_q == RUN);
  assign redirect        = redirect_q;
  assign misaligned      = (state_q == FAULT);
  assign misaligned_addr = maddr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed cycles push expected outputs,
// a monitor pops and compares one entry after each rising edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jalr_valid = 1'b0;
  logic [31:0] jalr_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic        misaligned;
  logic [31:0] misaligned_addr;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        pv;
    logic        rd;
    logic        mis;
    logic [31:0] ma;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jalr_valid      (jalr_valid),
    .jalr_target     (jalr_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .redirect        (redirect),
    .misaligned      (misaligned),
    .misaligned_addr (misaligned_addr)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] e_pc, input logic e_pv,
                         input logic e_rd, input logic e_mis, input logic [31:0] e_ma);
    chk({nm, ".pc"}, pc, e_pc);
    chk({nm, ".pc_valid"}, 32'(pc_valid), 32'(e_pv));
    chk({nm, ".redirect"}, 32'(redirect), 32'(e_rd));
    chk({nm, ".misaligned"}, 32'(misaligned), 32'(e_mis));
    chk({nm, ".misaligned_addr"}, misaligned_addr, e_ma);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk_all(mon_e.nm, mon_e.pc, mon_e.pv, mon_e.rd, mon_e.mis, mon_e.ma);
    end
  end

  // Called at a falling edge: drive one cycle of inputs, queue the outputs
  // expected after the next rising edge, return at the following falling edge.
  task automatic cyc(input string nm, input logic st, input logic fr,
                     input logic bt, input logic [31:0] btg,
                     input logic jv, input logic [31:0] jtg,
                     input logic tv, input logic [31:0] tvec,
                     input logic [31:0] e_pc, input logic e_pv, input logic e_rd,
                     input logic e_mis, input logic [31:0] e_ma);
    exp_t e;
    stall = st; fetch_ready = fr;
    branch_taken = bt; branch_target = btg;
    jalr_valid = jv; jalr_target = jtg;
    trap_valid = tv; trap_vector = tvec;
    e = '{nm, e_pc, e_pv, e_rd, e_mis, e_ma};
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall = 0; fetch_ready = 0; branch_taken = 0; branch_target = '0;
    jalr_valid = 0; jalr_target = '0; trap_valid = 0; trap_vector = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_all("reset", 32'h0, 0, 0, 0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk_all("boot", 32'h0, 0, 0, 0, 32'h0);

    cyc("boot_to_run", 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 32'h0);
    cyc("adv_4",       0, 1, 0, 0, 0, 0, 0, 0, 32'h4,  1, 0, 0, 32'h0);
    cyc("adv_8",       0, 1, 0, 0, 0, 0, 0, 0, 32'h8,  1, 0, 0, 32'h0);
    cyc("adv_c",       0, 1, 0, 0, 0, 0, 0, 0, 32'hc,  1, 0, 0, 32'h0);
    cyc("adv_10",      0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", 1, 1, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++)
      cyc("nready_hold", 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 32'h0);
    cyc("release_14",  0, 1, 0, 0, 0, 0, 0, 0, 32'h14, 1, 0, 0, 32'h0);

    cyc("prio_trap",   1, 0, 1, 32'h800, 1, 32'h401, 1, 32'h203, 32'h200, 1, 1, 0, 32'h0);
    cyc("rd_one_cyc",  0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 1, 0, 0, 32'h0);
    cyc("adv_204",     0, 1, 0, 0, 0, 0, 0, 0, 32'h204, 1, 0, 0, 32'h0);
    cyc("prio_jalr",   0, 1, 1, 32'h800, 1, 32'h401, 0, 0, 32'h400, 1, 1, 0, 32'h0);
    cyc("adv_404",     0, 1, 0, 0, 0, 0, 0, 0, 32'h404, 1, 0, 0, 32'h0);

    cyc("jalr_mask",   0, 1, 0, 0, 1, 32'h1001, 0, 0, 32'h1000, 1, 1, 0, 32'h0);
    cyc("br_fault",    0, 1, 1, 32'h1002, 0, 0, 0, 0, 32'h1000, 0, 0, 1, 32'h1002);
    cyc("fault_br_ign",0, 1, 1, 32'h2000, 0, 0, 0, 0, 32'h1000, 0, 0, 1, 32'h1002);
    cyc("fault_jr_ign",0, 1, 0, 0, 1, 32'h3000, 0, 0, 32'h1000, 0, 0, 1, 32'h1002);
    cyc("trap_exit",   1, 0, 0, 0, 0, 0, 1, 32'h100, 32'h100, 1, 1, 0, 32'h1002);
    cyc("adv_104",     0, 1, 0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 0, 32'h1002);
    cyc("jalr_fault",  0, 1, 0, 0, 1, 32'h2003, 0, 0, 32'h104, 0, 0, 1, 32'h2002);
    cyc("fault_idle",  0, 1, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 1, 32'h2002);
    cyc("trap_mask",   0, 1, 1, 32'h40, 0, 0, 1, 32'h7, 32'h4, 1, 1, 0, 32'h2002);

    cyc("br_top",      0, 1, 1, 32'hffff_fffc, 0, 0, 0, 0, 32'hffff_fffc, 1, 1, 0, 32'h2002);
    cyc("wrap_0",      0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h2002);
    cyc("adv_after",   0, 1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0, 32'h2002);
    cyc("br_fault5",   0, 1, 1, 32'h5, 0, 0, 0, 0, 32'h4, 0, 0, 1, 32'h5);

    clear_inputs();
    #2 rst_n = 1'b0;
    #1 chk_all("rst_in_fault", 32'h0, 0, 0, 0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk_all("boot2", 32'h0, 0, 0, 0, 32'h0);

    cyc("boot_trap",   0, 1, 1, 32'h80, 1, 32'h90, 1, 32'h43, 32'h40, 1, 1, 0, 32'h0);
    clear_inputs();
    #2 rst_n = 1'b0;
    #1 chk_all("rst_in_redir", 32'h0, 0, 0, 0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk_all("boot3", 32'h0, 0, 0, 0, 32'h0);

    cyc("boot_br_ign", 0, 1, 1, 32'h80, 1, 32'h90, 0, 0, 32'h0, 1, 0, 0, 32'h0);
    cyc("adv_post",    0, 1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0, 32'h0);

    clear_inputs();
    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, address width in bits (legal: 32 or 64).
REQ-002 Parameter RESET_VECTOR, default 0, pc value loaded on reset (low two bits SHALL be zero).
REQ-003 Parameter INSTR_BYTES, default 4, sequential increment.
REQ-004 Port clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port stall  input  1  hold pc, no advance.
REQ-007 Port fetch_ready  input  1  fetch stage accepts pc this cycle.
REQ-008 Port branch_taken  input  1  branch redirect request.
REQ-009 Port branch_target  input  XLEN  absolute branch target.
REQ-010 Port jalr_valid  input  1  indirect jump redirect request.
REQ-011 Port jalr_target  input  XLEN  raw jalr sum, bit 0 not yet cleared.
REQ-012 Port trap_valid  input  1  trap redirect request.
REQ-013 Port trap_vector  input  XLEN  trap handler address.
REQ-014 Port pc  output  XLEN  current fetch address.
REQ-015 Port pc_valid  output  1  pc is presentable to fetch.
REQ-016 Port redirect  output  1  one-cycle pulse, pc changed non-sequentially (flush younger stages).
REQ-017 Port misaligned  output  1  fault flag, level while in FAULT.
REQ-018 Port misaligned_addr  output  XLEN  offending target captured on fault entry.

Function
REQ-019 The FSM SHALL have states BOOT, RUN, FAULT.
REQ-020 BOOT SHALL last exactly one cycle after reset release, with pc_valid=0, then go to RUN.
REQ-021 In RUN, pc_valid SHALL be 1.
REQ-022 Advance SHALL occur only when pc_valid & fetch_ready & !stall & no redirect: pc <= pc + INSTR_BYTES, modulo 2^XLEN (wrap, no flag).
REQ-023 With pc_valid=1 and (!fetch_ready or stall) and no redirect, pc SHALL hold its value.
REQ-024 Redirect priority SHALL be trap_valid > jalr_valid > branch_taken.
REQ-025 Redirects SHALL override stall and fetch_ready.
REQ-026 Only the highest-priority request SHALL take effect; lower ones in the same cycle are discarded.
REQ-027 The effective jalr target SHALL be jalr_target with bit 0 forced to 0.
REQ-028 The effective trap target SHALL be trap_vector with bits [1:0] forced to 0.
REQ-029 An effective jalr or branch target with bits [1:0] != 0 SHALL, on that edge, move the FSM to FAULT, set misaligned=1, capture misaligned_addr, drop pc_valid, and leave pc unchanged.
REQ-030 An aligned redirect SHALL load pc with the target on that edge and assert redirect for the following cycle only.
REQ-031 In FAULT, branch, jalr, stall and fetch_ready SHALL be ignored.
REQ-032 Only trap_valid SHALL exit FAULT: pc <= trap target, state RUN, misaligned=0, redirect pulse.
REQ-033 trap_valid in BOOT SHALL load the trap target and enter RUN.
REQ-034 branch and jalr requests in BOOT SHALL be ignored.
REQ-035 misaligned_addr SHALL hold its captured value until the next fault entry or reset.

Reset
REQ-036 On rst_n low, asynchronously and regardless of clk: pc=RESET_VECTOR, state=BOOT, pc_valid=0, redirect=0, misaligned=0, misaligned_addr=0.
REQ-037 Reset asserted mid-redirect or in FAULT SHALL discard all pending state.

Structure
REQ-038 The package rv_core_pkg SHALL hold the pc_state_e enum (BOOT, RUN, FAULT), the XLEN default and INSTR_BYTES.
REQ-039 A combinational sub-module pc_redirect_arb SHALL perform priority selection, target masking and the alignment check.
REQ-040 pc_sequencer SHALL hold all registers and the FSM.

Verification
REQ-041 Reset release, fetch_ready=1, XLEN=32 -> pc_valid=0 for one cycle, then pc 0x0, 0x4, 0x8 on consecutive cycles.
REQ-042 pc=0x10, stall=1 for 3 cycles, then fetch_ready=0 for 2 cycles -> pc stays 0x10 throughout, then 0x14 once both are released.
REQ-043 Same cycle trap_valid (vector 0x203), jalr_valid (0x401) and branch_taken (0x800) -> pc=0x200 next cycle, redirect high for exactly one cycle.
REQ-044 jalr_target=0x1001 -> pc=0x1000, no fault; branch_target=0x1002 -> FAULT, misaligned=1, misaligned_addr=0x1002, pc_valid=0; later branches ignored; trap_valid with vector 0x100 -> pc=0x100, RUN.
REQ-045 pc=0xFFFFFFFC advancing -> pc=0x00000000, no fault; rst_n pulsed low mid-FAULT -> all outputs at reset values immediately.
